// File: rtl/inference_sequencer.sv
// ============================================================================
// Module      : inference_sequencer
// Description : Address and accumulate-strobe sequencer for a two-layer fully
//               connected network. It walks the layer-1 and layer-2 weight
//               ROMs source-major, bias row last. The acc_* strobes are
//               delayed to line up with the ROM read data. A one-cycle done
//               pulse marks the end of each pass.
//               Optional macro ROM_LAT2_EN selects a 2-cycle ROM latency
//               (default build: 1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inference_sequencer #(
    parameter int INPUT_COUNT   = 784,
    parameter int HIDDEN_COUNT  = 64,
    parameter int OUTPUT_COUNT  = 10,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] w_addr,
    output logic                     w_rd,
    output logic                     w_layer,
    output logic                     acc_clr,
    output logic                     acc_en,
    output logic                     acc_layer,
    output logic [5:0]               acc_dst,
    output logic [9:0]               acc_src,
    output logic                     acc_bias,
    output logic                     acc_last
);

    // Weight-ROM read latency; also the length of each drain state.
`ifdef ROM_LAT2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int N1 = (INPUT_COUNT + 1) * HIDDEN_COUNT;
    localparam int N2 = (HIDDEN_COUNT + 1) * OUTPUT_COUNT;

    localparam logic [ADDRESS_WIDTH-1:0] c_n1_last  = ADDRESS_WIDTH'(N1 - 1);
    localparam logic [ADDRESS_WIDTH-1:0] c_n2_last  = ADDRESS_WIDTH'(N2 - 1);
    localparam logic [5:0]               c_hid_last = 6'(HIDDEN_COUNT - 1);
    localparam logic [5:0]               c_out_last = 6'(OUTPUT_COUNT - 1);
    localparam logic [9:0]               c_in_src   = 10'(INPUT_COUNT);
    localparam logic [9:0]               c_hid_src  = 10'(HIDDEN_COUNT);
    localparam logic [0:0]               c_drain_last = 1'(LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLR      = 3'd1,
        S_L1       = 3'd2,
        S_L1_DRAIN = 3'd3,
        S_L2       = 3'd4,
        S_L2_DRAIN = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                     r_state;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_acc_clr;
    logic                       r_w_rd;
    logic                       r_w_layer;
    logic [ADDRESS_WIDTH-1:0]   r_w_addr;
    logic [9:0]                 r_src;
    logic [5:0]                 r_dst;
    logic [0:0]                 r_drain;

    // Accumulate-strobe delay line, stage LAT-1 drives the acc_* ports.
    logic [LAT-1:0]             r_p_en;
    logic [LAT-1:0]             r_p_layer;
    logic [LAT-1:0]             r_p_bias;
    logic [LAT-1:0]             r_p_last;
    logic [5:0]                 r_p_dst [LAT];
    logic [9:0]                 r_p_src [LAT];

    logic                       w_take_abort;
    logic                       w_dst_wrap;
    logic                       w_at_last;
    logic                       w_is_bias;
    logic                       w_drain_end;

    // Abort only matters once a pass is running; in IDLE it is ignored.
    assign w_take_abort = abort && (r_state != S_IDLE);
    assign w_dst_wrap   = r_w_layer ? (r_dst == c_out_last) : (r_dst == c_hid_last);
    assign w_at_last    = r_w_layer ? (r_w_addr == c_n2_last) : (r_w_addr == c_n1_last);
    assign w_is_bias    = r_w_layer ? (r_src == c_hid_src) : (r_src == c_in_src);
    assign w_drain_end  = (r_drain == c_drain_last);

    // Pass sequencing: state, address/source/destination counters and
    // the registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_acc_clr <= 1'b0;
            r_w_rd    <= 1'b0;
            r_w_layer <= 1'b0;
            r_w_addr  <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_drain   <= '0;
        end else if (w_take_abort) begin
            r_state   <= S_CLR;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_acc_clr <= 1'b1;
            r_w_rd    <= 1'b0;
            r_w_layer <= 1'b0;
            r_w_addr  <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_drain   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_CLR;
                        r_busy    <= 1'b1;
                        r_acc_clr <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_state   <= S_L1;
                    r_acc_clr <= 1'b0;
                    r_w_rd    <= 1'b1;
                    r_w_layer <= 1'b0;
                    r_w_addr  <= '0;
                    r_src     <= '0;
                    r_dst     <= '0;
                end
                S_L1, S_L2: begin
                    if (w_at_last) begin
                        r_state <= (r_state == S_L1) ? S_L1_DRAIN : S_L2_DRAIN;
                        r_w_rd  <= 1'b0;
                        r_drain <= '0;
                    end else begin
                        r_w_addr <= r_w_addr + ADDRESS_WIDTH'(1);
                        if (w_dst_wrap) begin
                            r_dst <= '0;
                            r_src <= r_src + 10'd1;
                        end else begin
                            r_dst <= r_dst + 6'd1;
                        end
                    end
                end
                S_L1_DRAIN: begin
                    if (w_drain_end) begin
                        r_state   <= S_L2;
                        r_w_rd    <= 1'b1;
                        r_w_layer <= 1'b1;
                        r_w_addr  <= '0;
                        r_src     <= '0;
                        r_dst     <= '0;
                        r_drain   <= '0;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_L2_DRAIN: begin
                    if (w_drain_end) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_drain <= '0;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_w_layer <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Delay the issue-side read info by the ROM latency; an abort kills
    // every strobe still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_en    <= '0;
            r_p_layer <= '0;
            r_p_bias  <= '0;
            r_p_last  <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_p_dst[i] <= '0;
                r_p_src[i] <= '0;
            end
        end else begin
            r_p_en[0]    <= r_w_rd & ~w_take_abort;
            r_p_layer[0] <= r_w_layer;
            r_p_bias[0]  <= r_w_rd & w_is_bias & ~w_take_abort;
            r_p_last[0]  <= r_w_rd & w_at_last & ~w_take_abort;
            r_p_dst[0]   <= r_dst;
            r_p_src[0]   <= r_src;
            for (int i = 1; i < LAT; i++) begin
                r_p_en[i]    <= r_p_en[i-1] & ~w_take_abort;
                r_p_layer[i] <= r_p_layer[i-1];
                r_p_bias[i]  <= r_p_bias[i-1] & ~w_take_abort;
                r_p_last[i]  <= r_p_last[i-1] & ~w_take_abort;
                r_p_dst[i]   <= r_p_dst[i-1];
                r_p_src[i]   <= r_p_src[i-1];
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign w_addr    = r_w_addr;
    assign w_rd      = r_w_rd;
    assign w_layer   = r_w_layer;
    assign acc_clr   = r_acc_clr;
    assign acc_en    = r_p_en[LAT-1];
    assign acc_layer = r_p_layer[LAT-1];
    assign acc_dst   = r_p_dst[LAT-1];
    assign acc_src   = r_p_src[LAT-1];
    assign acc_bias  = r_p_bias[LAT-1];
    assign acc_last  = r_p_last[LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_inference_sequencer.sv
// ============================================================================
// Module      : tb_inference_sequencer
// Description : Self-checking bench for inference_sequencer with small
//               network sizes. A pass-timeline model predicts all outputs
//               every cycle; directed passes pin literal cycle numbers.
//               Honours ROM_LAT2_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inference_sequencer;

    localparam int IC = 4;
    localparam int HC = 2;
    localparam int OC = 2;
    localparam int AW = 16;
    localparam int N1 = (IC + 1) * HC;
    localparam int N2 = (HC + 1) * OC;
`ifdef ROM_LAT2_EN
    localparam int LAT      = 2;
    localparam int EXP_DONE = 22;
`else
    localparam int LAT      = 1;
    localparam int EXP_DONE = 20;
`endif
    // Pass timeline, counted in cycles after the start-sampling edge.
    localparam int D   = N1 + N2 + 2 + 2 * LAT;
    localparam int L2S = N1 + 2 + LAT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, w_rd, w_layer, acc_clr, acc_en, acc_layer;
    logic          acc_bias, acc_last;
    logic [AW-1:0] w_addr;
    logic [5:0]    acc_dst;
    logic [9:0]    acc_src;

    int n_tests = 0;
    int n_fail  = 0;
    int mk      = 0;
    bit chk_on  = 1'b0;

    inference_sequencer #(
        .INPUT_COUNT  (IC),
        .HIDDEN_COUNT (HC),
        .OUTPUT_COUNT (OC),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .w_addr   (w_addr),
        .w_rd     (w_rd),
        .w_layer  (w_layer),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .acc_layer(acc_layer),
        .acc_dst  (acc_dst),
        .acc_src  (acc_src),
        .acc_bias (acc_bias),
        .acc_last (acc_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Which weight read (if any) is issued at pass cycle k.
    function automatic void issue(input int k, output bit v, output bit l, output int a);
        v = 1'b0; l = 1'b0; a = 0;
        if (k >= 2 && k <= N1 + 1) begin
            v = 1'b1; l = 1'b0; a = k - 2;
        end else if (k >= L2S && k < L2S + N2) begin
            v = 1'b1; l = 1'b1; a = k - L2S;
        end
    endfunction

    // Model: mk = position within the current pass, 0 when idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            mk = 0;
        else if (mk == 0)      mk = start ? 1 : 0;
        else if (abort)        mk = 1;
        else if (mk == D)      mk = 0;
        else                   mk = mk + 1;
    end

    bit e_rd, e_lay, e_en, e_al;
    int e_a, e_aa, dc, sc;

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            e_rd = 0; e_lay = 0; e_a = 0; e_en = 0; e_al = 0; e_aa = 0;
            if (mk != 0) begin
                issue(mk, e_rd, e_lay, e_a);
                issue(mk - LAT, e_en, e_al, e_aa);
            end
            chk("busy", busy, mk != 0);
            chk("done", done, mk == D);
            chk("acc_clr", acc_clr, mk == 1);
            chk("w_rd", w_rd, e_rd);
            chk("acc_en", acc_en, e_en);
            chk("acc_last", acc_last, e_en && (e_aa == (e_al ? N2 - 1 : N1 - 1)));
            if (e_rd) begin
                chk("w_addr", w_addr, e_a);
                chk("w_layer", w_layer, e_lay);
            end
            if (e_en) begin
                dc = e_al ? OC : HC;
                sc = e_al ? HC : IC;
                chk("acc_layer", acc_layer, e_al);
                chk("acc_dst", acc_dst, e_aa % dc);
                chk("acc_src", acc_src, e_aa / dc);
                chk("acc_bias", acc_bias, (e_aa / dc) == sc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pass from IDLE; optional abort cycle, optional second start.
    task automatic run_pass(input int ab_cyc, input int st2_cyc, input bit both);
        int cyc, done_n, done_at;
        start = 1'b1; abort = both;
        tick();
        start = 1'b0; abort = 1'b0;
        cyc = 1; done_n = 0; done_at = -1;
        chk("clr_cycle1", acc_clr, 1);
        while (cyc <= 60) begin
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
            end
            if (ab_cyc == 0 && cyc == 2) begin
                chk("first_addr", w_addr, 0);
                chk("first_rd", w_rd, 1);
            end
            if (ab_cyc == 0 && cyc == 11) begin
                chk("l1_last_addr", w_addr, 9);
                chk("l1_last_rd", w_rd, 1);
            end
            if (ab_cyc == 0 && cyc == 11 + LAT) begin
                chk("a9_en", acc_en, 1);
                chk("a9_dst", acc_dst, 1);
                chk("a9_src", acc_src, 4);
                chk("a9_bias", acc_bias, 1);
                chk("a9_last", acc_last, 1);
            end
            if (ab_cyc != 0 && cyc == ab_cyc) chk("abort_addr", w_addr, 5);
            if (ab_cyc != 0 && cyc == ab_cyc + 1) begin
                chk("abort_clr", acc_clr, 1);
                chk("abort_en", acc_en, 0);
            end
            if (ab_cyc != 0 && cyc == ab_cyc + 2) begin
                chk("restart_addr", w_addr, 0);
                chk("restart_rd", w_rd, 1);
            end
            abort = (cyc == ab_cyc);
            start = (cyc == st2_cyc);
            tick();
            cyc++;
        end
        start = 1'b0; abort = 1'b0;
        chk("done_count", done_n, 1);
        chk("done_cycle", done_at, (ab_cyc != 0) ? ab_cyc + EXP_DONE : EXP_DONE);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_w_rd", w_rd, 0);
        chk("rst_addr", w_addr, 0);
        rst_n = 1'b1;
        tick();

        run_pass(0, 0, 1'b0);   // plain pass
        repeat (2) tick();
        run_pass(0, 7, 1'b0);   // second start mid-pass is ignored
        repeat (2) tick();
        run_pass(7, 0, 1'b0);   // abort at layer-1 address 5
        repeat (2) tick();
        run_pass(0, 0, 1'b1);   // start with abort in IDLE acts as start

        // Asynchronous reset in the middle of layer 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_rd", w_rd, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_w_rd", w_rd, 0);
        chk("arst_acc_en", acc_en, 0);
        chk("arst_done", done, 0);
        tick();
        rst_n = 1'b1;
        run_pass(0, 0, 1'b0);

        // Randomised traffic with occasional abort and reset.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        start = 1'b0; abort = 1'b0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
